// File: rtl/prf_mw.sv
// prf_mw: multi-write physical register file between read-operand and writeback.
// Regular writeback ports plus round-robin arbitrated late writers. A late
// winner is inserted into the lowest idle write slot, or preempts port 0.
// Optional feature: define NCPU_PRF_BYPASS_EN to forward same-cycle write data
// to reads of the same nonzero address. Ports and latency are the same in both builds.
module prf_mw #(
  parameter int CONFIG_DW                = 64,
  parameter int CONFIG_PRF_AW            = 6,
  parameter int CONFIG_P_ISSUE_WIDTH     = 1,
  parameter int CONFIG_P_WRITEBACK_WIDTH = 1,
  parameter int CONFIG_NUM_LATE          = 2,
  localparam int DW = CONFIG_DW,
  localparam int AW = CONFIG_PRF_AW,
  localparam int NR = 2 * (1 << CONFIG_P_ISSUE_WIDTH),
  localparam int WW = 1 << CONFIG_P_WRITEBACK_WIDTH,
  localparam int NL = CONFIG_NUM_LATE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NR-1:0]    prf_RE,
  input  logic [NR*AW-1:0] prf_RADDR,
  output logic [NR*DW-1:0] prf_RDATA,
  input  logic [WW-1:0]    prf_WE,
  input  logic [WW*AW-1:0] prf_WADDR,
  input  logic [WW*DW-1:0] prf_WDATA,
  output logic [WW-1:0]    wb_ready,
  input  logic [NL-1:0]    late_valid,
  input  logic [NL*AW-1:0] late_waddr,
  input  logic [NL*DW-1:0] late_wdata,
  output logic [NL-1:0]    late_ready
);

  localparam int NE  = 1 << AW;
  localparam int RRW = (NL > 1) ? $clog2(NL) : 1;
  localparam int SW  = (WW > 1) ? $clog2(WW) : 1;

  logic [DW-1:0]  mem [NE];
  logic [DW-1:0]  rdata_q [NR];
  logic [DW-1:0]  rd_val [NR];
  logic [RRW-1:0] rr;
  logic [RRW-1:0] lwin;
  logic           lgrant;
  logic [SW-1:0]  slot;
  logic           slot_found;
  logic           ew_en [WW];
  logic [AW-1:0]  ew_addr [WW];
  logic [DW-1:0]  ew_data [WW];

  // Round-robin pick of the first requesting late writer at or after rr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    lgrant     = 1'b0;
    lwin       = '0;
    late_ready = '0;
    for (int off = 0; off < NL; off++) begin
      if (!lgrant && late_valid[(int'(rr) + off) % NL]) begin
        lgrant = 1'b1;
        lwin   = RRW'((int'(rr) + off) % NL);
      end
    end
    if (lgrant) late_ready[lwin] = 1'b1;
  end

  // Place the late winner in the lowest idle slot, else preempt port 0.
  always_comb begin
    slot       = '0;
    slot_found = 1'b0;
    for (int j = 0; j < WW; j++) begin
      if (!slot_found && !prf_WE[j]) begin
        slot_found = 1'b1;
        slot       = SW'(j);
      end
    end
    wb_ready = '1;
    if (lgrant && !slot_found) wb_ready[0] = 1'b0;
  end

  // Effective per-slot write: accepted regular write, or the inserted late write.
  always_comb begin
    for (int j = 0; j < WW; j++) begin
      ew_en[j]   = prf_WE[j] & wb_ready[j];
      ew_addr[j] = prf_WADDR[j*AW +: AW];
      ew_data[j] = prf_WDATA[j*DW +: DW];
      if (lgrant && int'(slot) == j) begin
        ew_en[j]   = 1'b1;
        ew_addr[j] = late_waddr[int'(lwin)*AW +: AW];
        ew_data[j] = late_wdata[int'(lwin)*DW +: DW];
      end
    end
  end

  // Storage update; ascending slot order lets the highest slot win a same-address collision.
  // NOTE: the storage array is deliberately left without reset; only its read path is cleared.
  always_ff @(posedge clk) begin
    for (int j = 0; j < WW; j++) begin
      if (ew_en[j] && ew_addr[j] != '0) mem[ew_addr[j]] <= ew_data[j];
    end
  end

  // Read value per port: array, optionally bypassed, forced to zero for register 0.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_val[i] = mem[prf_RADDR[i*AW +: AW]];
`ifdef NCPU_PRF_BYPASS_EN
      for (int j = 0; j < WW; j++) begin
        if (ew_en[j] && ew_addr[j] == prf_RADDR[i*AW +: AW]) rd_val[i] = ew_data[j];
      end
`endif
      if (prf_RADDR[i*AW +: AW] == '0) rd_val[i] = '0;
    end
  end

  // Registered read data; ports with RE low hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      for (int i = 0; i < NR; i++) rdata_q[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (prf_RE[i]) rdata_q[i] <= rd_val[i];
      end
    end
  end

  // Round-robin pointer advances past the winner on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr <= '0;
    else if (lgrant) rr <= (int'(lwin) == NL - 1) ? '0 : lwin + RRW'(1);
  end

  // Flatten read registers onto the output bus.
  always_comb begin
    for (int i = 0; i < NR; i++) prf_RDATA[i*DW +: DW] = rdata_q[i];
  end

endmodule

// File: tb/tb_prf_mw.sv
// Self-checking bench for prf_mw (default parameters: NR=4, WW=2, NL=2).
// Expected read data is pushed to a scoreboard queue when a read is driven and
// popped after the clock edge that produces it.
module tb_prf_mw;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int NR = 4;
  localparam int WW = 2;
  localparam int NL = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]    prf_RE;
  logic [NR*AW-1:0] prf_RADDR;
  logic [NR*DW-1:0] prf_RDATA;
  logic [WW-1:0]    prf_WE;
  logic [WW*AW-1:0] prf_WADDR;
  logic [WW*DW-1:0] prf_WDATA;
  logic [WW-1:0]    wb_ready;
  logic [NL-1:0]    late_valid;
  logic [NL*AW-1:0] late_waddr;
  logic [NL*DW-1:0] late_wdata;
  logic [NL-1:0]    late_ready;

  prf_mw dut (
    .clk(clk), .rst_n(rst_n),
    .prf_RE(prf_RE), .prf_RADDR(prf_RADDR), .prf_RDATA(prf_RDATA),
    .prf_WE(prf_WE), .prf_WADDR(prf_WADDR), .prf_WDATA(prf_WDATA),
    .wb_ready(wb_ready),
    .late_valid(late_valid), .late_waddr(late_waddr), .late_wdata(late_wdata),
    .late_ready(late_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] val;
  } rd_exp_t;

  rd_exp_t       sb_q[$];
  logic [DW-1:0] mdl [1 << AW];
  logic [DW-1:0] rd_exp [NR];
  int            rr_m;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    prf_RE = '0; prf_RADDR = '0;
    prf_WE = '0; prf_WADDR = '0; prf_WDATA = '0;
    late_valid = '0; late_waddr = '0; late_wdata = '0;
  endtask

  task automatic rd(input int i, input int a);
    prf_RE[i] = 1'b1;
    prf_RADDR[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int j, input int a, input logic [DW-1:0] d);
    prf_WE[j] = 1'b1;
    prf_WADDR[j*AW +: AW] = AW'(a);
    prf_WDATA[j*DW +: DW] = d;
  endtask

  task automatic lw(input int k, input int a, input logic [DW-1:0] d);
    late_valid[k] = 1'b1;
    late_waddr[k*AW +: AW] = AW'(a);
    late_wdata[k*DW +: DW] = d;
  endtask

  // One cycle: check readies against the model, queue expected reads, clock, compare.
  task automatic tick(input string tag);
    logic          grant, found;
    int            win, slot, a;
    logic [WW-1:0] exp_wbr;
    logic [NL-1:0] exp_lr;
    logic          en [WW];
    logic [AW-1:0] wa [WW];
    logic [DW-1:0] wd [WW];
    logic [DW-1:0] v;
    rd_exp_t       e;
    grant = 1'b0; win = 0; found = 1'b0; slot = 0;
    for (int off = 0; off < NL; off++) begin
      if (!grant && late_valid[(rr_m + off) % NL]) begin
        grant = 1'b1;
        win = (rr_m + off) % NL;
      end
    end
    exp_lr = '0;
    if (grant) exp_lr[win] = 1'b1;
    for (int j = 0; j < WW; j++) begin
      if (!found && !prf_WE[j]) begin
        found = 1'b1;
        slot = j;
      end
    end
    exp_wbr = '1;
    if (grant && !found) exp_wbr[0] = 1'b0;
    for (int j = 0; j < WW; j++) begin
      en[j] = prf_WE[j] && exp_wbr[j];
      wa[j] = prf_WADDR[j*AW +: AW];
      wd[j] = prf_WDATA[j*DW +: DW];
      if (grant && slot == j) begin
        en[j] = 1'b1;
        wa[j] = late_waddr[win*AW +: AW];
        wd[j] = late_wdata[win*DW +: DW];
      end
    end
    #1;
    check({tag, " late_ready"}, DW'(late_ready), DW'(exp_lr));
    check({tag, " wb_ready"}, DW'(wb_ready), DW'(exp_wbr));
    for (int i = 0; i < NR; i++) begin
      if (prf_RE[i]) begin
        a = int'(prf_RADDR[i*AW +: AW]);
        v = (a == 0) ? '0 : mdl[a];
`ifdef NCPU_PRF_BYPASS_EN
        for (int j = 0; j < WW; j++) begin
          if (a != 0 && en[j] && int'(wa[j]) == a) v = wd[j];
        end
`endif
        rd_exp[i] = v;
      end
      e.port = i;
      e.val  = rd_exp[i];
      sb_q.push_back(e);
    end
    @(posedge clk);
    for (int j = 0; j < WW; j++) begin
      if (en[j] && wa[j] != '0) mdl[wa[j]] = wd[j];
    end
    if (grant) rr_m = (win + 1) % NL;
    #1;
    for (int i = 0; i < NR; i++) begin
      e = sb_q.pop_front();
      check($sformatf("%s rdata%0d", tag, e.port), prf_RDATA[e.port*DW +: DW], e.val);
    end
  endtask

  initial begin
    rr_m = 0;
    for (int i = 0; i < NR; i++) rd_exp[i] = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset rdata", DW'(prf_RDATA != '0), '0);
    check("reset late_ready", DW'(late_ready), '0);
    check("reset wb_ready", DW'(wb_ready), DW'(2'b11));

    // Read register 0 on every port.
    for (int i = 0; i < NR; i++) rd(i, 0);
    tick("rd_zero");

    // Same-cycle write and read of address 5.
    idle(); wr(0, 5, 64'h11); tick("pre5");
    idle(); wr(0, 5, 64'hA5); rd(0, 5); tick("wr_rd_same");
    idle(); rd(0, 5); tick("reread5");
    check("reread5 const", prf_RDATA[DW-1:0], 64'hA5);

    // Late writer fills the idle slot 1.
    idle(); wr(0, 3, 64'h33); lw(0, 9, 64'h99);
    #1;
    check("fill late_ready", DW'(late_ready), DW'(2'b01));
    check("fill wb_ready", DW'(wb_ready), DW'(2'b11));
    tick("late_fill");
    idle(); rd(0, 9); rd(1, 3); rd(3, 9); tick("rd_fill");
    check("rd9 const", prf_RDATA[DW-1:0], 64'h99);

    // Both ports busy: late1 preempts port 0, then port 0 retries.
    idle(); wr(0, 10, 64'hA0); wr(1, 11, 64'hB0); lw(1, 12, 64'hC0);
    #1;
    check("preempt wb_ready", DW'(wb_ready), DW'(2'b10));
    check("preempt late_ready", DW'(late_ready), DW'(2'b10));
    tick("preempt");
    late_valid = '0;
    #1;
    check("retry wb_ready", DW'(wb_ready), DW'(2'b11));
    tick("retry");
    idle(); rd(0, 10); rd(1, 11); rd(2, 12); tick("rd_preempt");
    check("rd10 const", prf_RDATA[DW-1:0], 64'hA0);

    // Both late writers held: grants alternate and rr wraps.
    for (int c = 0; c < 5; c++) begin
      idle(); lw(0, 20, DW'(c)); lw(1, 21, DW'(c + 100));
      #1;
      check($sformatf("alt%0d grant", c), DW'(late_ready), (c % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
      tick($sformatf("alt%0d", c));
    end
    idle(); rd(0, 20); rd(1, 21); tick("rd_alt");

    // Writes to register 0 are accepted and discarded.
    idle(); wr(0, 0, 64'hFF); wr(1, 0, 64'hFF); rd(2, 0);
    #1;
    check("zero wb_ready", DW'(wb_ready), DW'(2'b11));
    tick("wr_zero");
    idle(); rd(0, 0); tick("rd_zero2");

    // Same-address collisions: highest effective slot wins.
    idle(); wr(0, 7, 64'h1); wr(1, 7, 64'h2); tick("coll_reg");
    idle(); wr(0, 8, 64'h5); lw(0, 8, 64'h6); tick("coll_late");
    idle(); rd(0, 7); rd(1, 8); tick("rd_coll");
    check("rd7 const", prf_RDATA[DW-1:0], 64'h2);
    check("rd8 const", prf_RDATA[2*DW-1:DW], 64'h6);

    // Preload 1..15, then random traffic over that range.
    for (int a = 1; a < 16; a++) begin
      idle(); wr(0, a, {$urandom, $urandom}); tick("preload");
    end
    for (int c = 0; c < 40; c++) begin
      idle();
      for (int j = 0; j < WW; j++) if ($urandom_range(1)) wr(j, $urandom_range(15, 1), {$urandom, $urandom});
      for (int k = 0; k < NL; k++) if ($urandom_range(1)) lw(k, $urandom_range(15, 1), {$urandom, $urandom});
      for (int i = 0; i < NR; i++) if ($urandom_range(1)) rd(i, $urandom_range(15, 1));
      tick("rand");
    end

    // Reset mid-operation clears read data and the pointer.
    idle(); lw(0, 2, 64'h2); tick("pre_rst");
    idle(); rd(0, 2);
    #3 rst_n = 1'b0;
    #1;
    check("midrst rdata", DW'(prf_RDATA != '0), '0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    for (int i = 0; i < NR; i++) rd_exp[i] = '0;
    lw(0, 30, 64'h30); lw(1, 31, 64'h31);
    #1;
    check("post_rst grant", DW'(late_ready), DW'(2'b01));
    tick("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/prf_mw.md
# prf_mw

Multi-write physical register file for the out-of-order backend. It sits between read-operand (RO) and writeback (WB) and holds `2^CONFIG_PRF_AW` entries of `CONFIG_DW` bits. It provides 2 read ports per issue slot and `2^CONFIG_P_WRITEBACK_WIDTH` regular write ports. A parametrised set of late writers (LSU, EPU, FPU, ...) is arbitrated round-robin and inserted into idle write slots, or into port 0 by preemption.

## Interface
Parameters:
- `CONFIG_DW`, 64: data width.
- `CONFIG_PRF_AW`, 6: physical register address width.
- `CONFIG_P_ISSUE_WIDTH`, 1: log2 issue width `IW`; read ports `NR = 2*IW`.
- `CONFIG_P_WRITEBACK_WIDTH`, 1: log2 writeback width `WW`.
- `CONFIG_NUM_LATE`, 2: number of late writers `NL`, range 1..8.

Ports:
- `clk` in 1: clock. The block has one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `prf_RE` in NR: per-port read enable.
- `prf_RADDR` in NR*AW: read addresses; port i is at `[i*AW +: AW]`.
- `prf_RDATA` out NR*DW: registered read data.
- `prf_WE` in WW: regular write enables.
- `prf_WADDR` in WW*AW: regular write addresses.
- `prf_WDATA` in WW*DW: regular write data.
- `wb_ready` out WW: regular write accepted this cycle.
- `late_valid` in NL: late write requests.
- `late_waddr` in NL*AW: late write addresses.
- `late_wdata` in NL*DW: late write data.
- `late_ready` out NL: late write accepted this cycle.

## Operation
- Physical register 0 is hardwired to zero. Writes to address 0 are accepted (ready asserted) and discarded.
- Regular port j writes when `prf_WE[j] & wb_ready[j]`.
- Late arbitration: at most one late grant per cycle.
  - A round-robin pointer `rr` (log2 NL bits, modulo NL) selects the first requesting writer at or after `rr`.
  - `late_ready[k]=1` only for the winner.
  - On a grant, `rr` becomes winner+1, wrapping from NL-1 to 0. With no grant, `rr` holds.
- Slot insertion for the late winner:
  - It takes the lowest-index port j with `prf_WE[j]=0`, and every `wb_ready` stays 1.
  - If every port is busy, it preempts port 0: `wb_ready[0]=0`, and the other ports stay ready.
  - `wb_ready` is combinational from `prf_WE` and `late_valid`. A stalled WB source holds its request.
- Same-address writes in one cycle: the highest effective port index wins, and the late write counts as the index of the port it occupies. All of those writes are still acknowledged.
- Read: when `prf_RE[i]` is high, `prf_RDATA[i]` is loaded at the next edge with `mem[RADDR]`, or 0 for address 0. When `prf_RE[i]` is low, `prf_RDATA[i]` holds its value.
- Storage array is not reset. Contents are X until written, except entry 0.

## Timing
- Reset values:
  - `prf_RDATA` all 0.
  - `rr` = 0.
  - `late_ready` = 0 (no request).
  - `wb_ready` = all 1 when no late request.
- Read latency: 1 cycle, RE/RADDR at edge N, data valid after edge N+1.
- Write visibility: a write at edge N is seen by a read issued in the cycle after N with no forwarding.
- Same-cycle write and read of one address: behaviour depends on the configuration macro below.
- Reset mid-operation:
  - `prf_RDATA` and `rr` clear immediately.
  - In-flight writes on the asserting edge are not guaranteed.
  - No stuck ready after `rst_n` deasserts.
- Boundary cases:
  - NL=1: `rr` is a constant 0.
  - WW=1: a late grant always either fills the single idle slot or preempts port 0.

## Configuration
- `NCPU_PRF_BYPASS_EN` defined:
  - A read issued in the same cycle as an accepted write to the same nonzero address returns the new write data.
  - With multiple matching writes, the priority winner's data is returned.
- Undefined: that read returns the pre-write array value, and the new value is visible one cycle later.
- Both builds use identical ports and latency.

## Test plan
- Reset then RE=all, RADDR=0: RDATA all 0, `late_ready`=0, `wb_ready`=all 1.
- Write port0 addr 5 = 0xA5, RE addr 5 in the same cycle: with BYPASS_EN, RDATA=0xA5 next cycle; without it, RDATA=old value, and a re-read one cycle later gives 0xA5.
- WW=2, `prf_WE`=2'b01, late0 valid addr 9 = 0x99: `late_ready[0]`=1, `wb_ready`=2'b11, both writes land, and a read of addr 9 gives 0x99.
- `prf_WE`=2'b11 and late1 valid: `wb_ready`=2'b10 and `late_ready[1]`=1. The next cycle with WE held and no late request gives `wb_ready`=2'b11, and port 0 data lands.
- NL=2, both late writers held valid for 4 cycles: grants alternate 0,1,0,1, and `rr` wraps to 0.
- Write 0xFF to addr 0 on every port: all ready, and a read of addr 0 returns 0. Two ports write addr 7 with 0x1 and 0x2: a read gives 0x2.
